// File: rtl/shot_session_ctrl.sv
// -----------------------------------------------------------------------------
// shot_session_ctrl
//
// Session sequencer for the basketball shot simulator. It runs NUM_SHOTS
// attempts. Each attempt has a per-shot countdown, tracks the ball flight,
// scores the make or miss, and holds the kinematic reset while the ball is
// re-spotted.
//
// Optional build macro: SHOT_BCD_EN
//   When defined, the block adds the output shot_bcd, which is {tens, ones} BCD
//   of shot_secs and is registered alongside it.
//
// Ports:
//   CLK100MHZ   in   system clock
//   rst_n       in   synchronous active-low reset
//   start       in   level; a rising edge starts a session from IDLE or OVER
//   shoot       in   level; a rising edge releases the ball in READY
//   make        in   pulse; the ball scored (wins over miss)
//   miss        in   pulse; the ball is out of bounds or has landed
//   kin_rst     out  high while the ball must be re-spotted
//   shot_secs   out  remaining seconds of the current shot (binary)
//   shots_left  out  attempts remaining in the session
//   score       out  session score, saturating at 2^SCORE_W-1
//   state       out  IDLE=0 READY=1 FLIGHT=2 RESULT=3 OVER=4
//   buzzer      out  one-cycle pulse when shot_secs reaches 0
//   game_over   out  high in OVER
//   shot_bcd    out  (SHOT_BCD_EN only) BCD of shot_secs
// -----------------------------------------------------------------------------
module shot_session_ctrl #(
    parameter int CLK_HZ      = 100_000_000,
    parameter int SHOT_SECS   = 24,
    parameter int NUM_SHOTS   = 5,
    parameter int FLIGHT_SECS = 4,
    parameter int RESULT_CYC  = 50_000_000,
    parameter int SCORE_PTS   = 2,
    parameter int SCORE_W     = 8
) (
    input  logic               CLK100MHZ,
    input  logic               rst_n,
    input  logic               start,
    input  logic               shoot,
    input  logic               make,
    input  logic               miss,
    output logic               kin_rst,
    output logic [6:0]         shot_secs,
    output logic [3:0]         shots_left,
    output logic [SCORE_W-1:0] score,
    output logic [2:0]         state,
    output logic               buzzer,
    output logic               game_over
`ifdef SHOT_BCD_EN
    ,
    output logic [7:0]         shot_bcd
`endif
);

    localparam int DIV_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int RES_W = (RESULT_CYC > 1) ? $clog2(RESULT_CYC) : 1;
    localparam int FLT_W = $clog2(FLIGHT_SECS + 1);

    typedef logic [SCORE_W:0] score_ext_t;

    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(CLK_HZ - 1);
    localparam logic [RES_W-1:0]   RES_LAST   = RES_W'(RESULT_CYC - 1);
    localparam logic [FLT_W-1:0]   FLT_LAST   = FLT_W'(FLIGHT_SECS - 1);
    localparam logic [6:0]         SECS_INIT  = 7'(SHOT_SECS);
    localparam logic [3:0]         SHOTS_INIT = 4'(NUM_SHOTS);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
    localparam score_ext_t         PTS_EXT    = score_ext_t'(SCORE_PTS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READY  = 3'd1,
        S_FLIGHT = 3'd2,
        S_RESULT = 3'd3,
        S_OVER   = 3'd4
    } state_t;

    // Saturating score add: clamps at the all-ones value instead of wrapping.
    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a);
        score_ext_t sum;
        sum = {1'b0, a} + PTS_EXT;
        if (sum > {1'b0, SCORE_MAX}) begin
            return SCORE_MAX;
        end
        return sum[SCORE_W-1:0];
    endfunction

`ifdef SHOT_BCD_EN
    function automatic logic [7:0] to_bcd(input logic [6:0] b);
        return {4'(b / 7'd10), 4'(b % 7'd10)};
    endfunction
`endif

    state_t               state_q, state_d;
    logic [6:0]           secs_q, secs_d;
    logic [3:0]           left_q, left_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic                 kin_q, kin_d;
    logic                 buzz_q, buzz_d;
    logic                 over_q, over_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [FLT_W-1:0]     flt_q, flt_d;
    logic [RES_W-1:0]     res_q, res_d;
    logic                 start_q, shoot_q;
    logic                 start_edge, shoot_edge, tick, reload;

    always_comb begin
        start_edge = start & ~start_q;
        shoot_edge = shoot & ~shoot_q;
        tick       = (div_q == DIV_LAST);

        state_d = state_q;
        secs_d  = secs_q;
        left_d  = left_q;
        score_d = score_q;
        flt_d   = flt_q;
        res_d   = res_q;
        buzz_d  = 1'b0;
        reload  = 1'b0;
        div_d   = tick ? '0 : div_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    reload = 1'b1;
                end
            end
            S_READY: begin
                if (tick && secs_q != 7'd0) begin
                    secs_d = secs_q - 7'd1;
                    buzz_d = (secs_q == 7'd1);
                end
                // A shot released on the expiring tick beats the violation.
                if (shoot_edge) begin
                    state_d = S_FLIGHT;
                    flt_d   = '0;
                end else if (tick && secs_q == 7'd1) begin
                    state_d = S_RESULT;
                    res_d   = '0;
                end
            end
            S_FLIGHT: begin
                // The countdown keeps running while the ball is in the air.
                // It only sounds the buzzer and otherwise has no effect.
                if (tick) begin
                    if (secs_q != 7'd0) begin
                        secs_d = secs_q - 7'd1;
                    end
                    buzz_d = (secs_q == 7'd1);
                    flt_d  = flt_q + 1'b1;
                end
                if (make) begin
                    score_d = sat_add(score_q);
                    state_d = S_RESULT;
                    res_d   = '0;
                end else if (miss || (tick && flt_q == FLT_LAST)) begin
                    state_d = S_RESULT;
                    res_d   = '0;
                end
            end
            S_RESULT: begin
                if (res_q == RES_LAST) begin
                    left_d = left_q - 4'd1;
                    if (left_q == 4'd1) begin
                        state_d = S_OVER;
                    end else begin
                        state_d = S_READY;
                        secs_d  = SECS_INIT;
                    end
                end else begin
                    res_d = res_q + 1'b1;
                end
            end
            S_OVER: begin
                if (start_edge) begin
                    reload = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (reload) begin
            state_d = S_READY;
            score_d = '0;
            left_d  = SHOTS_INIT;
            secs_d  = SECS_INIT;
        end

        // Restarting the divider on READY entry makes the first second full length.
        if (state_d == S_READY && state_q != S_READY) begin
            div_d = '0;
        end

        kin_d  = (state_d == S_IDLE) || (state_d == S_RESULT) || (state_d == S_OVER);
        over_d = (state_d == S_OVER);
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            secs_q  <= SECS_INIT;
            left_q  <= SHOTS_INIT;
            score_q <= '0;
            kin_q   <= 1'b1;
            buzz_q  <= 1'b0;
            over_q  <= 1'b0;
            div_q   <= '0;
            flt_q   <= '0;
            res_q   <= '0;
            start_q <= 1'b0;
            shoot_q <= 1'b0;
        end else begin
            state_q <= state_d;
            secs_q  <= secs_d;
            left_q  <= left_d;
            score_q <= score_d;
            kin_q   <= kin_d;
            buzz_q  <= buzz_d;
            over_q  <= over_d;
            div_q   <= div_d;
            flt_q   <= flt_d;
            res_q   <= res_d;
            start_q <= start;
            shoot_q <= shoot;
        end
    end

`ifdef SHOT_BCD_EN
    logic [7:0] bcd_q;

    always_ff @(posedge CLK100MHZ) begin
        if (!rst_n) begin
            bcd_q <= to_bcd(SECS_INIT);
        end else begin
            bcd_q <= to_bcd(secs_d);
        end
    end

    assign shot_bcd = bcd_q;
`endif

    assign state      = state_q;
    assign shot_secs  = secs_q;
    assign shots_left = left_q;
    assign score      = score_q;
    assign kin_rst    = kin_q;
    assign buzzer     = buzz_q;
    assign game_over  = over_q;

endmodule

// File: tb/tb_shot_session_ctrl.sv
module tb_shot_session_ctrl;

    localparam int P_HZ     = 10;
    localparam int P_SHOT   = 3;
    localparam int P_NUM    = 2;
    localparam int P_FLIGHT = 2;
    localparam int P_RES    = 5;
    localparam int P_PTS    = 2;
    localparam int P_SW     = 2;
    localparam int P_MAX    = (1 << P_SW) - 1;

    logic            CLK100MHZ = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            shoot = 1'b0;
    logic            make = 1'b0;
    logic            miss = 1'b0;
    logic            kin_rst;
    logic [6:0]      shot_secs;
    logic [3:0]      shots_left;
    logic [P_SW-1:0] score;
    logic [2:0]      state;
    logic            buzzer;
    logic            game_over;
`ifdef SHOT_BCD_EN
    logic [7:0]      shot_bcd;
`endif

    int checks = 0;
    int failures = 0;

    shot_session_ctrl #(
        .CLK_HZ(P_HZ), .SHOT_SECS(P_SHOT), .NUM_SHOTS(P_NUM), .FLIGHT_SECS(P_FLIGHT),
        .RESULT_CYC(P_RES), .SCORE_PTS(P_PTS), .SCORE_W(P_SW)
    ) dut (
        .CLK100MHZ(CLK100MHZ), .rst_n(rst_n), .start(start), .shoot(shoot),
        .make(make), .miss(miss), .kin_rst(kin_rst), .shot_secs(shot_secs),
        .shots_left(shots_left), .score(score), .state(state), .buzzer(buzzer),
        .game_over(game_over)
`ifdef SHOT_BCD_EN
        , .shot_bcd(shot_bcd)
`endif
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    // Reference model. Phases are 0 idle, 1 ready, 2 flight, 3 result, 4 over.
    // A second elapses after P_HZ clocks in the current second.
    int m_phase, m_secs, m_left, m_score, m_buzz;
    int m_clocks_in_sec, m_secs_in_air, m_result_clocks;
    bit m_start_prev, m_shoot_prev;

    task automatic mdl_reset();
        m_phase = 0; m_secs = P_SHOT; m_left = P_NUM; m_score = 0; m_buzz = 0;
        m_clocks_in_sec = 0; m_secs_in_air = 0; m_result_clocks = 0;
        m_start_prev = 0; m_shoot_prev = 0;
    endtask

    task automatic mdl_new_shot();
        m_phase = 1; m_secs = P_SHOT; m_clocks_in_sec = 0;
    endtask

    task automatic mdl_one_second();
        if (m_secs > 0) begin
            m_secs = m_secs - 1;
            if (m_secs == 0) m_buzz = 1;
        end
    endtask

    task automatic mdl_step(input bit s, input bit sh, input bit mk, input bit ms, input bit rn);
        bit s_rise, sh_rise, sec_done;
        if (!rn) begin
            mdl_reset();
            return;
        end
        s_rise = s && !m_start_prev;
        sh_rise = sh && !m_shoot_prev;
        m_start_prev = s;
        m_shoot_prev = sh;
        m_buzz = 0;
        m_clocks_in_sec = m_clocks_in_sec + 1;
        sec_done = (m_clocks_in_sec == P_HZ);
        if (sec_done) m_clocks_in_sec = 0;
        case (m_phase)
            0, 4: if (s_rise) begin m_score = 0; m_left = P_NUM; mdl_new_shot(); end
            1: begin
                if (sec_done) mdl_one_second();
                if (sh_rise) begin m_phase = 2; m_secs_in_air = 0; end
                else if (m_secs == 0) begin m_phase = 3; m_result_clocks = 0; end
            end
            2: begin
                if (sec_done) begin mdl_one_second(); m_secs_in_air++; end
                if (mk) begin
                    m_score = (m_score + P_PTS > P_MAX) ? P_MAX : m_score + P_PTS;
                    m_phase = 3; m_result_clocks = 0;
                end else if (ms || m_secs_in_air >= P_FLIGHT) begin
                    m_phase = 3; m_result_clocks = 0;
                end
            end
            3: begin
                m_result_clocks++;
                if (m_result_clocks == P_RES) begin
                    m_left--;
                    if (m_left == 0) m_phase = 4;
                    else mdl_new_shot();
                end
            end
            default: ;
        endcase
    endtask

    function automatic logic [18:0] mdl_vec();
        logic kin;
        kin = (m_phase == 0) || (m_phase == 3) || (m_phase == 4);
        return {kin, 7'(m_secs), 4'(m_left), P_SW'(m_score), 3'(m_phase), m_buzz[0], m_phase == 4};
    endfunction

    logic [18:0] act_bus;
    assign act_bus = {kin_rst, shot_secs, shots_left, score, state, buzzer, game_over};

    task automatic drive_cycle(input bit s, input bit sh, input bit mk, input bit ms, input bit rn);
        @(negedge CLK100MHZ);
        start = s; shoot = sh; make = mk; miss = ms; rst_n = rn;
        @(posedge CLK100MHZ);
        mdl_step(s, sh, mk, ms, rn);
        #1;
    endtask

    task automatic begin_session();
        drive_cycle(0, 0, 0, 0, 0);
        drive_cycle(1, 0, 0, 0, 1);
    endtask

    task automatic test_reset();
        drive_cycle(1, 1, 1, 1, 0);
        drive_cycle(0, 0, 0, 0, 0);
        checks++;
        if (state !== 3'd0 || shot_secs !== 7'd3 || shots_left !== 4'd2 || score !== 2'd0 ||
            kin_rst !== 1'b1 || buzzer !== 1'b0 || game_over !== 1'b0) begin
            failures++;
            $display("FAIL reset_values: got %h want %h", act_bus, {1'b1, 7'd3, 4'd2, 2'd0, 3'd0, 2'b00});
        end
        checks++;
        if (act_bus !== mdl_vec()) begin
            failures++; $display("FAIL reset_model: got %h want %h", act_bus, mdl_vec());
        end
    endtask

    task automatic test_violation();
        begin_session();
        checks++;
        if (state !== 3'd1 || kin_rst !== 1'b0) begin
            failures++; $display("FAIL start_to_ready: state=%0d kin=%0b want 1/0", state, kin_rst);
        end
        for (int n = 1; n <= 35; n++) begin
            drive_cycle(n < 20, 0, 0, 0, 1);
            checks++;
            if (act_bus !== mdl_vec()) begin
                failures++; $display("FAIL violation n=%0d: got %h want %h", n, act_bus, mdl_vec());
            end
            if (n == 10 || n == 20) begin
                checks++;
                if (shot_secs !== 7'(P_SHOT - n / 10) || buzzer !== 1'b0) begin
                    failures++; $display("FAIL countdown n=%0d: secs=%0d want %0d", n, shot_secs, P_SHOT - n / 10);
                end
            end
            if (n == 30) begin
                checks++;
                if (state !== 3'd3 || shot_secs !== 7'd0 || buzzer !== 1'b1 || kin_rst !== 1'b1) begin
                    failures++; $display("FAIL expiry: state=%0d secs=%0d buzz=%0b want 3/0/1", state, shot_secs, buzzer);
                end
            end
            if (n == 34) begin
                checks++;
                if (state !== 3'd3 || kin_rst !== 1'b1 || shots_left !== 4'd2) begin
                    failures++; $display("FAIL result_hold: state=%0d left=%0d want 3/2", state, shots_left);
                end
            end
            if (n == 35) begin
                checks++;
                if (state !== 3'd1 || shots_left !== 4'd1 || shot_secs !== 7'd3 || kin_rst !== 1'b0) begin
                    failures++; $display("FAIL result_exit: state=%0d left=%0d secs=%0d want 1/1/3", state, shots_left, shot_secs);
                end
            end
        end
    endtask

    task automatic test_make_miss();
        begin_session();
        for (int n = 1; n <= 18; n++) begin
            drive_cycle(0, n == 5 || n == 6 || n == 12, n == 6 || n == 14, n == 13, 1);
            checks++;
            if (act_bus !== mdl_vec()) begin
                failures++; $display("FAIL make_miss n=%0d: got %h want %h", n, act_bus, mdl_vec());
            end
            if (n == 5) begin
                checks++;
                if (state !== 3'd2) begin failures++; $display("FAIL shoot_edge: state=%0d want 2", state); end
            end
            if (n == 6) begin
                checks++;
                if (state !== 3'd3 || score !== 2'd2) begin
                    failures++; $display("FAIL make_score: state=%0d score=%0d want 3/2", state, score);
                end
            end
            if (n == 11) begin
                checks++;
                if (state !== 3'd1 || shot_secs !== 7'd3 || shots_left !== 4'd1) begin
                    failures++; $display("FAIL reload: state=%0d secs=%0d left=%0d want 1/3/1", state, shot_secs, shots_left);
                end
            end
            if (n == 18) begin
                checks++;
                if (state !== 3'd4 || game_over !== 1'b1 || score !== 2'd2 || shots_left !== 4'd0 || kin_rst !== 1'b1) begin
                    failures++; $display("FAIL game_over: state=%0d over=%0b score=%0d left=%0d want 4/1/2/0", state, game_over, score, shots_left);
                end
            end
        end
    endtask

    task automatic test_shoot_at_expiry();
        begin_session();
        for (int n = 1; n <= 55; n++) begin
            drive_cycle(0, n == 30, 0, 0, 1);
            checks++;
            if (act_bus !== mdl_vec()) begin
                failures++; $display("FAIL shot_vs_expiry n=%0d: got %h want %h", n, act_bus, mdl_vec());
            end
            if (n == 30) begin
                checks++;
                if (state !== 3'd2 || shot_secs !== 7'd0 || buzzer !== 1'b1 || shots_left !== 4'd2) begin
                    failures++; $display("FAIL shot_wins: state=%0d secs=%0d buzz=%0b left=%0d want 2/0/1/2", state, shot_secs, buzzer, shots_left);
                end
            end
            if (n == 40 || n == 50) begin
                checks++;
                if (buzzer !== 1'b0 || shot_secs !== 7'd0) begin
                    failures++; $display("FAIL buzz_once n=%0d: buzz=%0b secs=%0d want 0/0", n, buzzer, shot_secs);
                end
            end
            if (n == 50) begin
                checks++;
                if (state !== 3'd3 || shots_left !== 4'd2) begin
                    failures++; $display("FAIL late_timeout: state=%0d left=%0d want 3/2", state, shots_left);
                end
            end
        end
    endtask

    task automatic test_flight_timeout();
        begin_session();
        for (int n = 1; n <= 55; n++) begin
            drive_cycle(n == 43, n == 10 || n == 36 || n == 44 || n == 51, n == 37 || n == 45 || n == 52, n == 37, 1);
            checks++;
            if (act_bus !== mdl_vec()) begin
                failures++; $display("FAIL flight n=%0d: got %h want %h", n, act_bus, mdl_vec());
            end
            if (n == 29 || n == 30) begin
                checks++;
                if (state !== ((n == 29) ? 3'd2 : 3'd3) || score !== 2'd0) begin
                    failures++; $display("FAIL timeout n=%0d: state=%0d score=%0d", n, state, score);
                end
            end
            if (n == 37) begin
                checks++;
                if (state !== 3'd3 || score !== 2'd2) begin
                    failures++; $display("FAIL make_and_miss: state=%0d score=%0d want 3/2", state, score);
                end
            end
            if (n == 43) begin
                checks++;
                if (state !== 3'd1 || score !== 2'd0 || shots_left !== 4'd2 || shot_secs !== 7'd3 || game_over !== 1'b0) begin
                    failures++; $display("FAIL restart: state=%0d score=%0d left=%0d secs=%0d want 1/0/2/3", state, score, shots_left, shot_secs);
                end
            end
            if (n == 52) begin
                checks++;
                if (score !== 2'd3) begin
                    failures++; $display("FAIL saturate: score=%0d want 3", score);
                end
            end
        end
    endtask

    task automatic test_reset_mid_flight();
        begin_session();
        drive_cycle(0, 1, 0, 0, 1);
        drive_cycle(0, 1, 0, 0, 1);
        drive_cycle(0, 1, 0, 0, 0);
        checks++;
        if (state !== 3'd0 || shot_secs !== 7'd3 || shots_left !== 4'd2 || score !== 2'd0 ||
            kin_rst !== 1'b1 || buzzer !== 1'b0 || game_over !== 1'b0) begin
            failures++; $display("FAIL abort_reset: got %h want %h", act_bus, {1'b1, 7'd3, 4'd2, 2'd0, 3'd0, 2'b00});
        end
        for (int n = 0; n < 16; n++) begin
            drive_cycle(1, 1, 0, 0, 1);
            checks++;
            if (state !== 3'd1 || act_bus !== mdl_vec()) begin
                failures++; $display("FAIL held_shoot n=%0d: got %h want %h", n, act_bus, mdl_vec());
            end
        end
    endtask

    task automatic test_random();
        bit s, sh, mk, ms, rn;
        begin_session();
        for (int n = 0; n < 3000; n++) begin
            s  = ($urandom_range(0, 99) < 3);
            sh = ($urandom_range(0, 9) < 3);
            mk = ($urandom_range(0, 99) < 4);
            ms = ($urandom_range(0, 99) < 4);
            rn = ($urandom_range(0, 999) != 0);
            drive_cycle(s, sh, mk, ms, rn);
            checks++;
            if (act_bus !== mdl_vec()) begin
                failures++; $display("FAIL random n=%0d: got %h want %h", n, act_bus, mdl_vec());
            end
`ifdef SHOT_BCD_EN
            checks++;
            if (shot_bcd !== {4'(m_secs / 10), 4'(m_secs % 10)}) begin
                failures++; $display("FAIL bcd n=%0d: got %h want %0d", n, shot_bcd, m_secs);
            end
`endif
        end
    endtask

    initial begin
        mdl_reset();
        test_reset();
        test_violation();
        test_make_miss();
        test_shoot_at_expiry();
        test_flight_timeout();
        test_reset_mid_flight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
